alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Parametrised, key-tagged arbiter that shares one pipelined ALU (alu32-style key/op/A/B in, key/O out) among NCH requesting channels. It supersedes the fixed two-input keymux: it adds per-channel valid/ready handshakes, round-robin fairness, bounded outstanding operations per channel and result routing back to the issuing channel by key. It sits between producers (speed/position PID blocks, test stimulus) and the shared alu32 in the top level.

## Interface
Parameters:
- NCH, 4, number of requesting channels; must satisfy NCH <= 2^KEY_SIZE - 1
- KEY_SIZE, 4, key width; key 0 means "no operation"
- OPCODE_SIZE, 4, opcode width
- OPERAND_SIZE, 32, operand/result width
- MAX_OUT, 2, maximum in-flight operations per channel (1..7)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- en  in  1  grant enable; returns are still processed when low
- req_valid_i  in  NCH  per-channel request valid
- req_ready_o  out  NCH  per-channel accept (combinational)
- req_op_i  in  NCH*OPCODE_SIZE  packed opcodes, channel 0 in LSBs
- req_A_i, req_B_i  in  NCH*OPERAND_SIZE  packed operands
- resp_valid_o  out  NCH  one-cycle result strobe per channel
- resp_O_o  out  OPERAND_SIZE  result shared by all channels, qualified by resp_valid_o
- alu_key_o  out  KEY_SIZE  key issued to ALU
- alu_op_o  out  OPCODE_SIZE  opcode issued to ALU
- alu_A_o, alu_B_o  out  OPERAND_SIZE  operands issued to ALU
- alu_key_i  in  KEY_SIZE  key returned by ALU
- alu_O_i  in  OPERAND_SIZE  result returned by ALU
- err_o  out  1  sticky protocol error flag
- busy_o  out  1  high while any channel has operations in flight

## Operation
- Channel c is assigned the fixed key c+1.
- Per-channel outstanding counter out_cnt[c], width clog2(MAX_OUT+1).
- Eligible(c) = req_valid_i[c] & (out_cnt[c] < MAX_OUT) & en.
- Round-robin pointer ptr (0..NCH-1). The grant goes to the first eligible channel scanning ptr, ptr+1, … with wrap at NCH. At most one grant per cycle.
- req_ready_o[c] = 1 only for the granted channel; it is combinational from req_valid_i, out_cnt, ptr and en.
- On a grant to channel g:
  - Register alu_key_o = g+1, alu_op_o/A/B = channel g slices.
  - out_cnt[g]++.
  - ptr <= (g+1) mod NCH.
- With no grant: alu_key_o <= 0; op/A/B hold their previous values; ptr is unchanged.
- Return with alu_key_i = k != 0, k <= NCH and out_cnt[k-1] > 0:
  - resp_valid_o[k-1] pulses for one cycle; resp_O_o <= alu_O_i.
  - out_cnt[k-1]--.
- Return with k > NCH, or with out_cnt[k-1] == 0:
  - Result is dropped; no resp_valid_o.
  - err_o <= 1 and stays set until reset.
- alu_key_i = 0 is ignored.
- Grant and return on the same channel in the same cycle: out_cnt is unchanged.
- busy_o = OR over c of (out_cnt[c] != 0), registered.
- The block does not reorder. Results arrive in whatever order the ALU delivers them; the key alone routes them.

## Timing
- Reset (rst low, asynchronous) values:
  - alu_key_o/op/A/B = 0
  - resp_valid_o = 0, resp_O_o = 0
  - err_o = 0, busy_o = 0
  - ptr = 0, all out_cnt = 0
- Issue latency: request accepted at edge t (valid & ready) → alu_* present after edge t, i.e. one cycle.
- Return latency: alu_key_i/alu_O_i sampled at edge r → resp_valid_o/resp_O_o valid after edge r for exactly one cycle.
- Throughput: one issue and one return per cycle; one channel can sustain MAX_OUT in flight.
- Requesters must hold req_valid_i and operands stable until ready; the block does not latch unaccepted requests.
- Reset asserted mid-operation:
  - All counters clear and in-flight results are forgotten.
  - ALU returns arriving after reset release with stale keys hit out_cnt == 0 and set err_o. The integrator must also reset the ALU.

## Test plan
- Single request: ch0 ADD A=3, B=4 → ready[0] same cycle; next cycle alu_key_o=1, A=3, B=4; model ALU returns key 1, O=7 three cycles later → resp_valid_o=4'b0001 one cycle, resp_O_o=7; busy_o returns to 0.
- Contention: ch0–ch3 valid continuously, ALU returns immediately → grant order 0,1,2,3,0,…; alu_key_o sequence 1,2,3,4,1.
- Outstanding limit: ch2 valid with ALU never returning → exactly MAX_OUT=2 grants (key 3 twice), then ready[2]=0. One return with key 3 → next cycle one further grant.
- Protocol errors: inject key 9 with NCH=4 → err_o=1, no resp_valid. Inject key 2 with out_cnt[1]=0 → err_o stays 1.
- Simultaneous grant and return on ch1 with out_cnt[1]=1 → out_cnt[1] stays 1; resp_valid_o[1] pulses.
- en=0 with requests pending and 2 in flight → no grants, alu_key_o=0, both returns delivered. Then assert rst low mid-stream → every output is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one pipelined, key-tagged ALU among NCH requesting channels.
// Grants are round-robin. Each channel has a cap on operations in flight.
// Results are routed back to the issuing channel using the returned key.
// Channel c always uses key c+1. Key 0 means "no operation" on both ALU ports.
module alu_arbiter #(
    parameter int NCH          = 4,
    parameter int KEY_SIZE     = 4,
    parameter int OPCODE_SIZE  = 4,
    parameter int OPERAND_SIZE = 32,
    parameter int MAX_OUT      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NCH-1:0]              req_valid_i,
    output logic [NCH-1:0]              req_ready_o,
    input  logic [NCH*OPCODE_SIZE-1:0]  req_op_i,
    input  logic [NCH*OPERAND_SIZE-1:0] req_A_i,
    input  logic [NCH*OPERAND_SIZE-1:0] req_B_i,
    output logic [NCH-1:0]              resp_valid_o,
    output logic [OPERAND_SIZE-1:0]     resp_O_o,
    output logic [KEY_SIZE-1:0]         alu_key_o,
    output logic [OPCODE_SIZE-1:0]      alu_op_o,
    output logic [OPERAND_SIZE-1:0]     alu_A_o,
    output logic [OPERAND_SIZE-1:0]     alu_B_o,
    input  logic [KEY_SIZE-1:0]         alu_key_i,
    input  logic [OPERAND_SIZE-1:0]     alu_O_i,
    output logic                        err_o,
    output logic                        busy_o
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0]  out_cnt  [NCH];
    logic [CW-1:0]  cnt_next [NCH];
    logic [PW-1:0]  ptr;
    logic [NCH-1:0] eligible;
    logic           grant_found;
    logic [PW-1:0]  grant_idx;
    logic [NCH-1:0] grant_vec;
    logic [NCH-1:0] ret_hit;
    logic           ret_err;
    logic           busy_next;

    // A channel may be granted when it requests, has room below its cap and granting is enabled.
    // Holding reset also blocks grants, so req_ready_o reads 0 while reset is held.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NCH; c++) begin
            eligible[c] = req_valid_i[c] && (out_cnt[c] < CW'(MAX_OUT)) && en && rst;
        end
    end

    // Round-robin scan: the first eligible channel starting at ptr wins. Indices wrap at NCH.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NCH) j = j - NCH;
            if (!grant_found && eligible[j]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(j);
            end
        end
    end

    // Expand the grant into a one-hot vector. This vector drives the ready handshake and the counter increments.
    always_comb begin
        grant_vec = '0;
        for (int c = 0; c < NCH; c++) begin
            grant_vec[c] = grant_found && (int'(grant_idx) == c);
        end
        req_ready_o = grant_vec;
    end

    // Decode the returned key. A return is valid only if its channel has work in flight.
    // Any other nonzero key is a protocol error.
    always_comb begin
        ret_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            ret_hit[c] = (alu_key_i == KEY_SIZE'(c + 1)) && (out_cnt[c] != '0);
        end
        ret_err = (alu_key_i != '0) && (ret_hit == '0);
    end

    // Next counter values. A grant and a return on the same channel in one cycle cancel out.
    // busy is derived from these next values, so busy_o tracks the registered counters exactly.
    always_comb begin
        busy_next = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            cnt_next[c] = out_cnt[c];
            if (grant_vec[c] && !ret_hit[c]) cnt_next[c] = out_cnt[c] + CW'(1);
            if (ret_hit[c] && !grant_vec[c]) cnt_next[c] = out_cnt[c] - CW'(1);
            busy_next = busy_next | (cnt_next[c] != '0);
        end
    end

    // Arbitration state: per-channel outstanding counters and the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) out_cnt[c] <= '0;
            ptr <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) out_cnt[c] <= cnt_next[c];
            if (grant_found) begin
                ptr <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + PW'(1);
            end
        end
    end

    // Registered ALU issue port.
    // On an idle cycle only the key drops to 0; the operands keep their previous values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_key_o <= '0;
            alu_op_o  <= '0;
            alu_A_o   <= '0;
            alu_B_o   <= '0;
        end else if (grant_found) begin
            alu_key_o <= KEY_SIZE'(grant_idx) + KEY_SIZE'(1);
            alu_op_o  <= req_op_i[grant_idx*OPCODE_SIZE +: OPCODE_SIZE];
            alu_A_o   <= req_A_i[grant_idx*OPERAND_SIZE +: OPERAND_SIZE];
            alu_B_o   <= req_B_i[grant_idx*OPERAND_SIZE +: OPERAND_SIZE];
        end else begin
            alu_key_o <= '0;
        end
    end

    // Registered response side: the one-cycle strobe, the shared result, the sticky error flag and busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_o <= '0;
            resp_O_o     <= '0;
            err_o        <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            resp_valid_o <= ret_hit;
            if (ret_hit != '0) resp_O_o <= alu_O_i;
            if (ret_err) err_o <= 1'b1;
            busy_o <= busy_next;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven checks of alu_arbiter with NCH=4, MAX_OUT=2.
// The bench plays the ALU and drives alu_key_i/alu_O_i directly in each table row.
// Hand-written sequences cover the enable gating, busy_o and asynchronous reset.
module tb_alu_arbiter;

    localparam int NCH = 4;
    localparam int KS  = 4;
    localparam int OS  = 4;
    localparam int DS  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NCH-1:0]  req_valid_i;
    logic [NCH-1:0]  req_ready_o;
    logic [NCH*OS-1:0] req_op_i;
    logic [NCH*DS-1:0] req_A_i;
    logic [NCH*DS-1:0] req_B_i;
    logic [NCH-1:0]  resp_valid_o;
    logic [DS-1:0]   resp_O_o;
    logic [KS-1:0]   alu_key_o;
    logic [OS-1:0]   alu_op_o;
    logic [DS-1:0]   alu_A_o;
    logic [DS-1:0]   alu_B_o;
    logic [KS-1:0]   alu_key_i;
    logic [DS-1:0]   alu_O_i;
    logic            err_o;
    logic            busy_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        en;
        logic [3:0]  ret_key;
        logic [31:0] ret_o;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_key;
        logic [3:0]  exp_resp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    alu_arbiter #(.NCH(NCH), .KEY_SIZE(KS), .OPCODE_SIZE(OS), .OPERAND_SIZE(DS), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_A_i(req_A_i), .req_B_i(req_B_i),
        .resp_valid_o(resp_valid_o), .resp_O_o(resp_O_o),
        .alu_key_o(alu_key_o), .alu_op_o(alu_op_o), .alu_A_o(alu_A_o), .alu_B_o(alu_B_o),
        .alu_key_i(alu_key_i), .alu_O_i(alu_O_i),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] valid, input logic enable,
                                  input logic [3:0] key, input logic [31:0] result);
        req_valid_i = valid;
        en          = enable;
        alu_key_i   = key;
        alu_O_i     = result;
    endtask

    initial begin
        // Channel c: op = c+1, A = 3+16c, B = 4+16c (channel 0 is ADD 3,4)
        for (int c = 0; c < NCH; c++) begin
            req_op_i[c*OS +: OS] = OS'(c + 1);
            req_A_i[c*DS +: DS]  = 32'(3 + 16*c);
            req_B_i[c*DS +: DS]  = 32'(4 + 16*c);
        end

        //                 valid  en  rkey  retO   ready  key   resp  err
        vecs.push_back('{4'h1, 1'b1, 4'd0, 32'd0,  4'h1, 4'd1, 4'h0, 1'b0}); // single request ch0
        vecs.push_back('{4'h0, 1'b1, 4'd0, 32'd0,  4'h0, 4'd0, 4'h0, 1'b0});
        vecs.push_back('{4'h0, 1'b1, 4'd0, 32'd0,  4'h0, 4'd0, 4'h0, 1'b0});
        vecs.push_back('{4'h0, 1'b1, 4'd1, 32'd7,  4'h0, 4'd0, 4'h1, 1'b0}); // result 7 back
        vecs.push_back('{4'hF, 1'b1, 4'd0, 32'd0,  4'h2, 4'd2, 4'h0, 1'b0}); // contention, ptr=1
        vecs.push_back('{4'hF, 1'b1, 4'd2, 32'd50, 4'h4, 4'd3, 4'h2, 1'b0});
        vecs.push_back('{4'hF, 1'b1, 4'd3, 32'd51, 4'h8, 4'd4, 4'h4, 1'b0});
        vecs.push_back('{4'hF, 1'b1, 4'd4, 32'd52, 4'h1, 4'd1, 4'h8, 1'b0}); // wrap to ch0
        vecs.push_back('{4'hF, 1'b1, 4'd1, 32'd53, 4'h2, 4'd2, 4'h1, 1'b0});
        vecs.push_back('{4'h0, 1'b1, 4'd2, 32'd54, 4'h0, 4'd0, 4'h2, 1'b0});
        vecs.push_back('{4'h4, 1'b1, 4'd0, 32'd0,  4'h4, 4'd3, 4'h0, 1'b0}); // ch2 limit
        vecs.push_back('{4'h4, 1'b1, 4'd0, 32'd0,  4'h4, 4'd3, 4'h0, 1'b0});
        vecs.push_back('{4'h4, 1'b1, 4'd0, 32'd0,  4'h0, 4'd0, 4'h0, 1'b0}); // capped at 2
        vecs.push_back('{4'h4, 1'b1, 4'd0, 32'd0,  4'h0, 4'd0, 4'h0, 1'b0});
        vecs.push_back('{4'h4, 1'b1, 4'd3, 32'd60, 4'h0, 4'd0, 4'h4, 1'b0}); // one returns
        vecs.push_back('{4'h4, 1'b1, 4'd0, 32'd0,  4'h4, 4'd3, 4'h0, 1'b0}); // one more grant
        vecs.push_back('{4'h0, 1'b1, 4'd3, 32'd61, 4'h0, 4'd0, 4'h4, 1'b0});
        vecs.push_back('{4'h0, 1'b1, 4'd3, 32'd62, 4'h0, 4'd0, 4'h4, 1'b0});
        vecs.push_back('{4'h0, 1'b1, 4'd9, 32'd99, 4'h0, 4'd0, 4'h0, 1'b1}); // key > NCH
        vecs.push_back('{4'h0, 1'b1, 4'd2, 32'd98, 4'h0, 4'd0, 4'h0, 1'b1}); // key 2, nothing in flight
        vecs.push_back('{4'h2, 1'b1, 4'd0, 32'd0,  4'h2, 4'd2, 4'h0, 1'b1}); // ch1 count -> 1
        vecs.push_back('{4'h2, 1'b1, 4'd2, 32'd70, 4'h2, 4'd2, 4'h2, 1'b1}); // grant+return ch1
        vecs.push_back('{4'h0, 1'b1, 4'd2, 32'd71, 4'h0, 4'd0, 4'h2, 1'b1}); // still 1 in flight
        vecs.push_back('{4'h0, 1'b1, 4'd2, 32'd72, 4'h0, 4'd0, 4'h0, 1'b1}); // now 0: dropped

        apply_stimulus(4'h0, 1'b1, 4'd0, 32'd0);
        rst = 1'b0;
        #12;
        check_output("reset_key",   32'(alu_key_o),    32'd0);
        check_output("reset_A",     alu_A_o,           32'd0);
        check_output("reset_resp",  32'(resp_valid_o), 32'd0);
        check_output("reset_err",   32'(err_o),        32'd0);
        check_output("reset_busy",  32'(busy_o),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].en, vecs[i].ret_key, vecs[i].ret_o);
            #1;
            check_output($sformatf("ready[%0d]", i), 32'(req_ready_o), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check_output($sformatf("key[%0d]", i),  32'(alu_key_o),    32'(vecs[i].exp_key));
            check_output($sformatf("resp[%0d]", i), 32'(resp_valid_o), 32'(vecs[i].exp_resp));
            check_output($sformatf("err[%0d]", i),  32'(err_o),        32'(vecs[i].exp_err));
            if (vecs[i].exp_key != 4'd0) begin
                check_output($sformatf("op[%0d]", i), 32'(alu_op_o), 32'(vecs[i].exp_key));
                check_output($sformatf("A[%0d]", i),  alu_A_o, 32'(3 + 16*(int'(vecs[i].exp_key) - 1)));
                check_output($sformatf("B[%0d]", i),  alu_B_o, 32'(4 + 16*(int'(vecs[i].exp_key) - 1)));
            end
            if (vecs[i].exp_resp != 4'h0) begin
                check_output($sformatf("resp_O[%0d]", i), resp_O_o, vecs[i].ret_o);
            end
        end

        // Enable gating: two in flight (ch0, ch1), then en low with requests pending.
        // ptr is 2 here, so the scan reaches ch0 first.
        apply_stimulus(4'h3, 1'b1, 4'd0, 32'd0);
        #1 check_output("en_ready0", 32'(req_ready_o), 32'h1);
        @(posedge clk); #1;
        check_output("en_key0", 32'(alu_key_o), 32'd1);
        #1 check_output("en_ready1", 32'(req_ready_o), 32'h2);
        @(posedge clk); #1;
        check_output("en_key1", 32'(alu_key_o), 32'd2);
        apply_stimulus(4'h3, 1'b0, 4'd0, 32'd0);
        #1 check_output("en_off_ready", 32'(req_ready_o), 32'h0);
        @(posedge clk); #1;
        check_output("en_off_key", 32'(alu_key_o), 32'd0);
        check_output("busy_inflight", 32'(busy_o), 32'd1);
        apply_stimulus(4'h3, 1'b0, 4'd1, 32'd80);
        @(posedge clk); #1;
        check_output("en_off_resp0", 32'(resp_valid_o), 32'h1);
        check_output("en_off_O0", resp_O_o, 32'd80);
        apply_stimulus(4'h3, 1'b0, 4'd2, 32'd81);
        @(posedge clk); #1;
        check_output("en_off_resp1", 32'(resp_valid_o), 32'h2);
        check_output("en_off_O1", resp_O_o, 32'd81);
        apply_stimulus(4'h0, 1'b0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 check_output("busy_idle", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of traffic.
        // ptr is 2 here, so ch0 is granted first.
        apply_stimulus(4'h3, 1'b1, 4'd0, 32'd0);
        @(posedge clk); #1;
        apply_stimulus(4'h3, 1'b1, 4'd1, 32'd90);
        @(posedge clk); #1;
        check_output("pre_rst_key",  32'(alu_key_o),    32'd2);
        check_output("pre_rst_resp", 32'(resp_valid_o), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_output("rst_ready", 32'(req_ready_o),  32'h0);
        check_output("rst_key",   32'(alu_key_o),    32'd0);
        check_output("rst_op",    32'(alu_op_o),     32'd0);
        check_output("rst_A",     alu_A_o,           32'd0);
        check_output("rst_B",     alu_B_o,           32'd0);
        check_output("rst_resp",  32'(resp_valid_o), 32'h0);
        check_output("rst_O",     resp_O_o,          32'd0);
        check_output("rst_err",   32'(err_o),        32'd0);
        check_output("rst_busy",  32'(busy_o),       32'd0);
        apply_stimulus(4'h0, 1'b1, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // A stale key returned after reset hits an empty counter and is flagged as an error.
        apply_stimulus(4'h0, 1'b1, 4'd2, 32'd123);
        @(posedge clk); #1;
        check_output("stale_resp", 32'(resp_valid_o), 32'h0);
        check_output("stale_err",  32'(err_o),        32'd1);
        apply_stimulus(4'h0, 1'b1, 4'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
